lcd_uart_pixel_rx: RTL and testbench



---
 rtl/lcd_pkg.sv | 16 +
 rtl/lcd_pix_fifo.sv | 59 +++++
 rtl/lcd_uart_pixel_rx.sv | 189 ++++++++++++++++++
 tb/tb_lcd_uart_pixel_rx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and receiver state encoding for the UART-fed LCD pixel path.
package lcd_pkg;

  localparam int unsigned RGB565_W         = 16;
  localparam int unsigned LCD_WIDTH        = 240;
  localparam int unsigned LCD_HEIGHT       = 135;
  localparam int unsigned FRAME_PIXELS_DEF = LCD_WIDTH * LCD_HEIGHT;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

endpackage

// File: rtl/lcd_pix_fifo.sv
// First-word-fall-through synchronous FIFO; head word reads as zero when empty.
module lcd_pix_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A push into a full FIFO is only taken when the same cycle frees a slot.
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = empty ? '0 : mem[rptr_q];

  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (do_rd && !do_wr) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/lcd_uart_pixel_rx.sv
// 8N1 UART receiver that pairs bytes into RGB565 pixels, tags frame starts and
// buffers them for the LCD streamer.
module lcd_uart_pixel_rx
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 27000000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned IDLE_BITS    = 20
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ser_rx,
  output logic [RGB565_W-1:0] pix_data,
  output logic                pix_sof,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                frame_err,
  output logic                overflow
);

  localparam int unsigned DIV      = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = DIV / 2;
  localparam int unsigned CNT_W    = $clog2(DIV);
  localparam int unsigned IDX_W    = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int unsigned IDLE_LIM = IDLE_BITS * DIV;
  localparam int unsigned IDLE_W   = $clog2(IDLE_LIM + 1);
  localparam int unsigned CNT_FW   = $clog2(FIFO_DEPTH) + 1;

  logic sync1_q, rx_q, rx_prev_q, fall;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d, hi_q, hi_d;
  logic             brk_q, brk_d, phase_q, phase_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic                push, pop;
  logic [RGB565_W:0]   push_data, head;
  logic                fifo_full, fifo_empty;
  logic [CNT_FW-1:0]   fifo_count;
  logic                unused_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= 1'b1;
      rx_q      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= ser_rx;
      rx_q      <= sync1_q;
      rx_prev_q <= rx_q;
    end
  end

  assign fall = rx_prev_q & ~rx_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    hi_d      = hi_q;
    brk_d     = brk_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    idle_d    = idle_q;
    ferr_d    = 1'b0;
    push      = 1'b0;
    push_data = {idx_q == '0, hi_q, shift_q};

    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (fall) begin
          state_d = RxStart;
          idle_d  = '0;
        end else if (rx_q && idle_q < IDLE_W'(IDLE_LIM)) begin
          idle_d = idle_q + 1'b1;
          // A long quiet line means the host gave up mid-frame: realign.
          if (idle_q == IDLE_W'(IDLE_LIM - 1)) begin
            phase_d = 1'b0;
            idx_d   = '0;
          end
        end
      end
      RxStart: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (brk_q) begin
          cnt_d = '0;
          if (rx_q) begin
            brk_d   = 1'b0;
            state_d = RxIdle;
          end
        end else if (cnt_q == CNT_W'(DIV - 1)) begin
          cnt_d = '0;
          if (rx_q) begin
            state_d = RxIdle;
            if (!phase_q) begin
              hi_d    = shift_q;
              phase_d = 1'b1;
            end else begin
              push    = 1'b1;
              phase_d = 1'b0;
              idx_d   = (idx_q == IDX_W'(FRAME_PIXELS - 1)) ? '0 : idx_q + 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            phase_d = 1'b0;
            brk_d   = 1'b1;
          end
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign pop   = pix_valid & pix_ready;
  assign ovf_d = ovf_q | (push & fifo_full & ~pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hi_q    <= '0;
      brk_q   <= 1'b0;
      phase_q <= 1'b0;
      idx_q   <= '0;
      idle_q  <= '0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hi_q    <= hi_d;
      brk_q   <= brk_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      idle_q  <= idle_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  lcd_pix_fifo #(
    .WIDTH (RGB565_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign unused_count = ^fifo_count;

  assign pix_valid = ~fifo_empty;
  assign pix_sof   = head[RGB565_W];
  assign pix_data  = head[RGB565_W-1:0];
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_lcd_uart_pixel_rx.sv
// Directed + random UART pixel traffic against a transaction-level model of
// byte pairing, frame indexing, idle resync and buffer occupancy.
module tb_lcd_uart_pixel_rx;

  localparam int unsigned CLK_FREQ  = 1600000;
  localparam int unsigned BAUD      = 100000;
  localparam int unsigned DIV       = CLK_FREQ / BAUD;
  localparam int unsigned FRAME     = 8;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned IDLE_BITS = 20;
  localparam int          SHORT     = 2;
  localparam int          LONG      = 25;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ser_rx = 1'b1;
  logic        pix_ready = 1'b0;
  logic [15:0] pix_data;
  logic        pix_sof, pix_valid, frame_err, overflow;

  always #5 clk = ~clk;

  lcd_uart_pixel_rx #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .FRAME_PIXELS (FRAME),
    .FIFO_DEPTH   (DEPTH),
    .IDLE_BITS    (IDLE_BITS)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ser_rx    (ser_rx),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int n_assert = 0, n_fail = 0;

  // Reference model state
  logic [16:0] exp_q[$];
  int          exp_idx = 0, exp_ferr = 0, exp_pushed = 0, exp_flushed = 0, exp_sofs = 0;
  bit          exp_phase = 0;
  logic [7:0]  exp_hi = 8'h00;

  // Observations
  int          ready_mode = 0;
  int          ferr_cnt = 0, hs_cnt = 0, valid_cycles = 0, sof_seen = 0;
  int          lat_cnt = 0, lat_val = -1;
  logic [16:0] last_word = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int cycles);
    ser_rx = v;
    repeat (cycles) begin
      @(negedge clk);
      lat_cnt++;
      if (pix_valid && lat_val < 0) lat_val = lat_cnt;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop, input int gap);
    lat_cnt = 0;
    lat_val = -1;
    drive(1'b0, DIV);
    for (int i = 0; i < 8; i++) drive(b[i], DIV);
    if (!good_stop) begin
      exp_phase = 0;
      exp_ferr++;
    end else if (!exp_phase) begin
      exp_hi    = b;
      exp_phase = 1;
    end else begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back({exp_idx == 0, exp_hi, b});
        exp_pushed++;
        if (exp_idx == 0) exp_sofs++;
      end
      exp_idx   = (exp_idx + 1) % FRAME;
      exp_phase = 0;
    end
    drive(good_stop, DIV);
    drive(1'b1, gap * DIV);
    if (gap >= IDLE_BITS + 2) begin
      exp_phase = 0;
      exp_idx   = 0;
    end
  endtask

  task automatic send_pixel(input logic [15:0] p, input int gap);
    send_byte(p[15:8], 1'b1, SHORT);
    send_byte(p[7:0], 1'b1, gap);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || pix_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_model_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_valid_low"}, 32'(pix_valid), 32'd0);
  endtask

  // Consumer: drives pix_ready and scores every handshake against the model.
  initial begin
    logic [16:0] prev_word, e;
    bit prev_hold, prev_ferr;
    prev_word = '0;
    prev_hold = 0;
    prev_ferr = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_hold = 0;
        prev_ferr = 0;
        pix_ready = 1'b0;
      end else begin
        case (ready_mode)
          0:       pix_ready = 1'b0;
          1:       pix_ready = 1'b1;
          default: pix_ready = 1'($urandom_range(0, 1));
        endcase
        if (prev_hold) chk("hold_stable", 32'({pix_valid, pix_sof, pix_data}), 32'({1'b1, prev_word}));
        if (frame_err) begin
          ferr_cnt++;
          chk("ferr_width", 32'(prev_ferr), 32'd0);
        end
        prev_ferr = frame_err;
        if (pix_valid) valid_cycles++;
        if (pix_valid && pix_ready) begin
          hs_cnt++;
          chk("pending_pixels", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pixel", 32'({pix_sof, pix_data}), 32'(e));
            if (pix_sof) sof_seen++;
            last_word = {pix_sof, pix_data};
          end
        end
        prev_hold = pix_valid && !pix_ready;
        prev_word = {pix_sof, pix_data};
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int vc0, hs0, sof0, sofx0, ferr0;

    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_sof", 32'(pix_sof), 32'd0);
    chk("rst_data", 32'(pix_data), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Basic pixel with exact pin-to-valid latency
    ready_mode = 1;
    vc0 = valid_cycles;
    hs0 = hs_cnt;
    send_byte(8'hF8, 1'b1, SHORT);
    send_byte(8'h00, 1'b1, LONG);
    chk("basic_latency", 32'(lat_val), 32'(2 + DIV / 2 + 9 * DIV + 1));
    drain("basic");
    chk("basic_valid_cycles", 32'(valid_cycles - vc0), 32'd1);
    chk("basic_handshakes", 32'(hs_cnt - hs0), 32'd1);
    chk("basic_word", 32'(last_word), 32'h1F800);
    chk("basic_ferr", 32'(ferr_cnt), 32'd0);

    // Random pixels across several frame wraps with a stalling consumer
    ready_mode = 2;
    hs0 = hs_cnt;
    sof0 = sof_seen;
    sofx0 = exp_sofs;
    for (int i = 0; i < 20; i++) send_pixel(16'($urandom), (i == 19) ? LONG : SHORT);
    drain("wrap");
    chk("wrap_handshakes", 32'(hs_cnt - hs0), 32'd20);
    chk("wrap_sof_count", 32'(sof_seen - sof0), 32'(exp_sofs - sofx0));

    // Bad stop bit discards the pending high byte
    ready_mode = 1;
    hs0 = hs_cnt;
    send_byte(8'h77, 1'b1, SHORT);
    send_byte(8'h12, 1'b0, SHORT);
    send_byte(8'hAB, 1'b1, SHORT);
    send_byte(8'hCD, 1'b1, LONG);
    drain("ferr");
    chk("ferr_count", 32'(ferr_cnt), 32'(exp_ferr));
    chk("ferr_handshakes", 32'(hs_cnt - hs0), 32'd1);
    chk("ferr_word", 32'(last_word[15:0]), 32'h0000ABCD);

    // Idle gap after a lone high byte realigns phase and frame index
    send_pixel(16'h1111, SHORT);
    send_byte(8'h55, 1'b1, LONG);
    send_byte(8'h12, 1'b1, SHORT);
    send_byte(8'h34, 1'b1, LONG);
    drain("resync");
    chk("resync_word", 32'(last_word), 32'h11234);

    // Short low glitch: no byte, no error
    vc0 = valid_cycles;
    ferr0 = ferr_cnt;
    drive(1'b0, DIV / 2 - 3);
    drive(1'b1, 4 * DIV);
    chk("glitch_no_pixel", 32'(valid_cycles - vc0), 32'd0);
    chk("glitch_no_err", 32'(ferr_cnt - ferr0), 32'd0);
    send_pixel(16'h2468, LONG);
    drain("glitch");
    chk("glitch_after_word", 32'(last_word[15:0]), 32'h00002468);

    // Overflow with a stalled consumer
    ready_mode = 0;
    for (int i = 1; i <= 17; i++) begin
      send_pixel(16'(i), (i == 17) ? LONG : SHORT);
      if (i == 16) chk("ovf_before_full", 32'(overflow), 32'd0);
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_valid", 32'(pix_valid), 32'd1);
    chk("ovf_head", 32'(pix_data), 32'd1);
    ready_mode = 1;
    hs0 = hs_cnt;
    drain("ovf");
    chk("ovf_pops", 32'(hs_cnt - hs0), 32'd16);
    chk("ovf_last", 32'(last_word[15:0]), 32'd16);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset in the middle of a data bit
    ready_mode = 0;
    for (int i = 0; i < 3; i++) send_pixel(16'hA5A5, SHORT);
    drive(1'b0, DIV);
    drive(1'b1, DIV);
    drive(1'b0, DIV);
    drive(1'b1, DIV / 2);
    chk("prereset_valid", 32'(pix_valid), 32'd1);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(pix_valid), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_data", 32'(pix_data), 32'd0);
    chk("arst_sof", 32'(pix_sof), 32'd0);
    exp_flushed += exp_q.size();
    exp_q.delete();
    exp_idx = 0;
    exp_phase = 0;
    ser_rx = 1'b1;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    ready_mode = 1;
    send_pixel(16'hBEEF, LONG);
    drain("post_reset");
    chk("post_reset_word", 32'(last_word), 32'h1BEEF);
    chk("post_reset_ovf", 32'(overflow), 32'd0);
    chk("total_handshakes", 32'(hs_cnt), 32'(exp_pushed - exp_flushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
